// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the four-digit seven-segment scan driver.
// Contents:
//   - DIGIT_COUNT / IDX_W : number of scanned digits and index width
//   - digit_idx_e         : scan index, named by what each position shows
//   - GLYPH_*             : active-low segment patterns {a,b,c,d,e,f,g,dp}
//   - AN_*                : active-low anode patterns per scan index
//   - anode_for()         : index -> anode pattern lookup
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam int DIGIT_COUNT = 4;
    localparam int IDX_W       = $clog2(DIGIT_COUNT);

    // Index 0 is the rightmost digit; the two right digits carry the glyph
    // for the counting direction, the two left digits carry the decimal value.
    typedef enum logic [IDX_W-1:0] {
        DIG_DIR_R = 2'd0,
        DIG_DIR_L = 2'd1,
        DIG_ONES  = 2'd2,
        DIG_TENS  = 2'd3
    } digit_idx_e;

    // Segment glyphs, active-low, dp always off (LSB = 1)
    localparam logic [7:0] GLYPH_0     = 8'b0000_0011;
    localparam logic [7:0] GLYPH_1     = 8'b1001_1111;
    localparam logic [7:0] GLYPH_2     = 8'b0010_0101;
    localparam logic [7:0] GLYPH_3     = 8'b0000_1101;
    localparam logic [7:0] GLYPH_4     = 8'b1001_1001;
    localparam logic [7:0] GLYPH_5     = 8'b0100_1001;
    localparam logic [7:0] GLYPH_6     = 8'b0100_0001;
    localparam logic [7:0] GLYPH_7     = 8'b0001_1111;
    localparam logic [7:0] GLYPH_8     = 8'b0000_0001;
    localparam logic [7:0] GLYPH_9     = 8'b0000_1001;
    localparam logic [7:0] GLYPH_UP    = 8'b0011_1011;
    localparam logic [7:0] GLYPH_DOWN  = 8'b1100_0111;
    localparam logic [7:0] GLYPH_BLANK = 8'b1111_1111;

    // Anode enables, active-low
    localparam logic [3:0] AN_IDX0 = 4'b1110;
    localparam logic [3:0] AN_IDX1 = 4'b1101;
    localparam logic [3:0] AN_IDX2 = 4'b1011;
    localparam logic [3:0] AN_IDX3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    function automatic logic [3:0] anode_for(input digit_idx_e idx);
        logic [3:0] pattern;
        pattern = AN_OFF;
        case (idx)
            DIG_DIR_R: pattern = AN_IDX0;
            DIG_DIR_L: pattern = AN_IDX1;
            DIG_ONES:  pattern = AN_IDX2;
            DIG_TENS:  pattern = AN_IDX3;
            default:   pattern = AN_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// ----------------------------------------------------------------------------
// seg7_digit_decoder
// Combinational BCD digit to seven-segment glyph mapping.
// Ports:
//   digit [3:0] in  : BCD digit; values 10..15 are not decimal and show dark
//   glyph [7:0] out : active-low segments {a,b,c,d,e,f,g,dp}
// ----------------------------------------------------------------------------
module seg7_digit_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        case (digit)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed four-digit seven-segment driver. The left two digits show
// the counter value in decimal (00..15), the right two show a direction glyph.
// Inputs are captured once per scan frame so a frame never mixes two values.
//
// Parameters:
//   REFRESH_BITS : prescaler width; each digit is lit for 2^REFRESH_BITS clocks
// Ports:
//   clk            in  : system clock
//   rst            in  : asynchronous, active-high reset
//   value_in [3:0] in  : counter value 0..15
//   dir_in         in  : 1 = counting up, 0 = counting down
//   blank          in  : turns all digits off; scanning keeps running
//   an [3:0]       out : digit enables, active-low, an[0] = rightmost
//   seg [7:0]      out : segments, active-low, {a,b,c,d,e,f,g,dp}
// Build option:
//   SEG7_BLANK_LEADING_ZERO_EN : when defined, the tens digit is dark for
//                                values below 10 instead of showing "0".
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value_in,
    input  logic       dir_in,
    input  logic       blank,
    output logic [3:0] an,
    output logic [7:0] seg
);

    logic [REFRESH_BITS-1:0] prescaler_reg;
    digit_idx_e              idx_reg;
    logic [3:0]              val_s_reg;
    logic                    dir_s_reg;
    logic [3:0]              an_reg;
    logic [3:0]              an_next;
    logic [7:0]              seg_reg;
    logic [7:0]              seg_next;

    logic                    tick;
    logic                    frame_end;
    logic                    tens;
    logic [3:0]              ones;
    logic [3:0]              digit_sel;
    logic [7:0]              digit_glyph;

    assign tick      = &prescaler_reg;
    // Last tick of index 3: the index wraps and the shadow registers reload
    // on the same edge, so the new value starts exactly at the next frame.
    assign frame_end = tick && (idx_reg == DIG_TENS);

    // Value range is 0..15, so a single compare-and-subtract replaces a divider.
    assign tens      = (val_s_reg >= 4'd10);
    assign ones      = tens ? (val_s_reg - 4'd10) : val_s_reg;
    assign digit_sel = (idx_reg == DIG_TENS) ? {3'b000, tens} : ones;

    seg7_digit_decoder u_digit_decoder (
        .digit (digit_sel),
        .glyph (digit_glyph)
    );

    always_comb begin
        an_next  = anode_for(idx_reg);
        seg_next = digit_glyph;

        if (idx_reg == DIG_DIR_R || idx_reg == DIG_DIR_L) begin
            seg_next = dir_s_reg ? GLYPH_UP : GLYPH_DOWN;
        end

`ifdef SEG7_BLANK_LEADING_ZERO_EN
        if (idx_reg == DIG_TENS && !tens) begin
            an_next  = AN_OFF;
            seg_next = GLYPH_BLANK;
        end
`endif

        if (blank) begin
            an_next  = AN_OFF;
            seg_next = GLYPH_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_reg <= '0;
            idx_reg       <= DIG_DIR_R;
            val_s_reg     <= 4'd0;
            dir_s_reg     <= 1'b1;
            an_reg        <= AN_OFF;
            seg_reg       <= GLYPH_BLANK;
        end else begin
            prescaler_reg <= prescaler_reg + 1'b1;
            if (tick) begin
                idx_reg <= digit_idx_e'(idx_reg + 2'd1);
            end
            if (frame_end) begin
                val_s_reg <= value_in;
                dir_s_reg <= dir_in;
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with REFRESH_BITS=2 (4 clocks per digit,
// 16 clocks per frame). Edges are numbered from reset release: after edge k
// the outputs show scan index ((k-1)/4)%4, and shadow registers reload on
// edges that are multiples of 16.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam logic [7:0] G0   = 8'b0000_0011;
    localparam logic [7:0] G1   = 8'b1001_1111;
    localparam logic [7:0] G2   = 8'b0010_0101;
    localparam logic [7:0] G3   = 8'b0000_1101;
    localparam logic [7:0] G5   = 8'b0100_1001;
    localparam logic [7:0] G9   = 8'b0000_1001;
    localparam logic [7:0] GUP  = 8'b0011_1011;
    localparam logic [7:0] GDN  = 8'b1100_0111;
    localparam logic [7:0] GOFF = 8'b1111_1111;

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    localparam logic [3:0] Z_AN  = 4'b1111;
    localparam logic [7:0] Z_SEG = 8'b1111_1111;
`else
    localparam logic [3:0] Z_AN  = 4'b0111;
    localparam logic [7:0] Z_SEG = 8'b0000_0011;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] value_in;
    logic       dir_in;
    logic       blank;
    logic [3:0] an;
    logic [7:0] seg;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    seg7_scan_driver #(.REFRESH_BITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .dir_in   (dir_in),
        .blank    (blank),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end else begin
            $display("chk  %s ok val=%b", tag, got);
        end
    endtask

    // Advance to just after edge e (counted from reset release).
    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic see(input string tag, input int e, input logic [3:0] a, input logic [7:0] s);
        goto(e);
        check_val({tag, ".an"}, {4'h0, an}, {4'h0, a});
        check_val({tag, ".seg"}, seg, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        blank    = 1'b0;
        value_in = 4'd7;
        dir_in   = 1'b1;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_hold.an", {4'h0, an}, 8'h0F);
        end
        check_val("rst_hold.seg", seg, GOFF);

        rst      = 1'b0;
        cyc      = 0;
        value_in = 4'd12;
        dir_in   = 1'b0;

        // frame 0 runs on reset shadow values (0, up)
        see("rel",   1,  4'b1110, GUP);
        see("f0_i2", 9,  4'b1011, G0);
        see("f0_i3", 13, Z_AN,    Z_SEG);

        // frame 1: 12, down
        see("scan_i0", 17, 4'b1110, GDN);
        see("scan_i1", 21, 4'b1101, GDN);
        see("scan_i2", 25, 4'b1011, G2);
        see("scan_i3", 29, 4'b0111, G1);
        value_in = 4'd3;

        // frame 2: 3; input changes to 9 while index 1 is active
        see("cap_i0", 33, 4'b1110, GDN);
        see("cap_i1", 37, 4'b1101, GDN);
        value_in = 4'd9;
        see("cap_i2_old", 41, 4'b1011, G3);
        see("cap_i3_old", 45, Z_AN,    Z_SEG);

        // frame 3: 9
        see("cap_i2_new", 57, 4'b1011, G9);
        see("v9_tens",    61, Z_AN,    Z_SEG);
        value_in = 4'd15;

        // frame 4: 15
        see("v15_ones", 73, 4'b1011, G5);
        see("v15_tens", 77, 4'b0111, G1);
        value_in = 4'd10;
        dir_in   = 1'b1;

        // frame 5: 10, up
        see("v10_dir",  81, 4'b1110, GUP);
        see("v10_ones", 89, 4'b1011, G0);
        see("v10_tens", 93, 4'b0111, G1);

        // blank pulse of 6 cycles inside frame 6
        see("pre_blank", 98, 4'b1110, GUP);
        blank = 1'b1;
        for (int e = 99; e <= 104; e++) begin
            if (e == 104) begin
                goto(e);
                blank = 1'b0;
                check_val($sformatf("blank_e%0d.an", e), {4'h0, an}, 8'h0F);
                check_val($sformatf("blank_e%0d.seg", e), seg, GOFF);
            end else begin
                see($sformatf("blank_e%0d", e), e, 4'b1111, GOFF);
            end
        end
        see("post_blank0", 105, 4'b1011, G0);
        see("post_blank1", 106, 4'b1011, G0);
        see("post_i3",     109, 4'b0111, G1);
        see("post_next",   113, 4'b1110, GUP);

        // asynchronous reset while index 2 is showing
        see("pre_arst", 121, 4'b1011, G0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_now.an", {4'h0, an}, 8'h0F);
        check_val("arst_now.seg", seg, GOFF);
        repeat (2) @(posedge clk);
        #1;
        check_val("arst_hold.an", {4'h0, an}, 8'h0F);
        rst = 1'b0;
        cyc = 0;

        // restart from index 0 with val_s=0, dir_s=up
        see("rs_i0", 1,  4'b1110, GUP);
        see("rs_i1", 5,  4'b1101, GUP);
        see("rs_i2", 9,  4'b1011, G0);
        see("rs_i3", 13, Z_AN,    Z_SEG);
        see("rs_f1", 17, 4'b1110, GUP);
        see("rs_f1_ones", 25, 4'b1011, G0);
        see("rs_f1_tens", 29, 4'b0111, G1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
